// File: rtl/stopwatch_bcd_counter.sv
// Multi-digit BCD stopwatch counting synchronised rising edges of the divider's slow square wave.
// Start/stop toggles run/pause; clear zeroes the count and returns to idle.
module stopwatch_bcd_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  slow_clock,
  input  logic                  start_stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  tick,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [4*DIGITS-1:0] digits_inc;
  logic                all_nines;
  logic                count_en;

  // slow_clock is data, not a clock: two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slow_clock;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick_d = s2_q & ~s3_q;

  // Ripple BCD increment: each digit steps only when every lower digit is 9
  always_comb begin
    logic       carry;
    logic [3:0] nib;
    digits_inc = '0;
    carry      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = digits_q[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          nib = 4'd0;
        end else begin
          nib   = nib + 4'd1;
          carry = 1'b0;
        end
      end
      digits_inc[4*i +: 4] = nib;
    end
    all_nines = carry;
  end

  // Count decision uses the pre-transition state; clear always wins
  assign count_en = tick_q && (state_q == StRun) && !clear;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    wrap_d   = 1'b0;
    if (clear) begin
      state_d  = StIdle;
      digits_d = '0;
    end else begin
      if (count_en) begin
        digits_d = digits_inc;
        wrap_d   = all_nines;
      end
      if (start_stop) begin
        unique case (state_q)
          StIdle:  state_d = StRun;
          StRun:   state_d = StPause;
          StPause: state_d = StRun;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      digits_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == StRun);
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Randomised and directed bench for stopwatch_bcd_counter against an integer-count reference model.
module tb_stopwatch_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MAXCNT = 9999;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                slow = 1'b0;
  logic                ss = 1'b0;
  logic                clr = 1'b0;
  logic [4*DIGITS-1:0] digits;
  logic                running;
  logic                tick;
  logic                wrap;

  stopwatch_bcd_counter #(.DIGITS(DIGITS)) dut (
    .clock_in  (clk),
    .reset     (reset),
    .slow_clock(slow),
    .start_stop(ss),
    .clear     (clr),
    .digits    (digits),
    .running   (running),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;
  int wrap_seen = 0;
  bit chk_en = 1'b0;

  // Reference model: count as a plain integer, state 0=idle 1=run 2=pause,
  // samp[j] = slow_clock value sampled j+1 edges ago.
  int m_count = 0;
  int m_st    = 0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;
  bit samp [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [4*DIGITS-1:0] to_bcd(int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      bit cnt;
      @(posedge clk or posedge reset);
      if (reset) begin
        m_count = 0; m_st = 0; m_tick = 0; m_wrap = 0;
        samp[0] = 0; samp[1] = 0; samp[2] = 0;
      end else begin
        cnt    = m_tick && (m_st == 1) && !clr;
        m_wrap = 1'b0;
        if (clr) begin
          m_count = 0;
          m_st    = 0;
        end else begin
          if (cnt) begin
            if (m_count == MAXCNT) begin
              m_count = 0;
              m_wrap  = 1'b1;
            end else begin
              m_count = m_count + 1;
            end
          end
          if (ss) m_st = (m_st == 1) ? 2 : 1;
        end
        // rise seen two edges ago, low three edges ago
        m_tick  = samp[1] && !samp[2];
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = slow;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        chk("digits_model", 32'(digits), 32'(to_bcd(m_count)));
        chk("running_model", 32'(running), 32'(m_st == 1));
        chk("tick_model", 32'(tick), 32'(m_tick));
        chk("wrap_model", 32'(wrap), 32'(m_wrap));
      end
      if (!reset && tick) tick_seen++;
      if (!reset && wrap) wrap_seen++;
    end
  end

  task automatic settle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic periods(int n);
    repeat (n) begin
      @(negedge clk) slow = 1'b1;
      settle(2);
      @(negedge clk) slow = 1'b0;
      settle(2);
    end
  endtask

  task automatic pulse_ss();
    @(negedge clk) ss = 1'b1;
    @(negedge clk) ss = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  // Raise slow_clock and present the command in the cycle where tick is visible
  task automatic rise_with_cmd(bit s, bit c);
    @(negedge clk) slow = 1'b1;
    settle(2);
    @(negedge clk) begin ss = s; clr = c; end
    @(negedge clk) begin ss = 1'b0; clr = 1'b0; end
    @(negedge clk) slow = 1'b0;
    settle(3);
  endtask

  task automatic rand_phase(int n, bit v);
    repeat (n) begin
      @(negedge clk);
      slow = v;
      ss   = ($urandom_range(0, 7) == 0);
      clr  = ($urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    int t0;
    settle(3);
    @(negedge clk) reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_running", 32'(running), 32'h0);

    // idle: ticks appear, no counting
    t0 = tick_seen;
    periods(10);
    settle(5);
    chk("idle_ticks", 32'(tick_seen - t0), 32'd10);
    chk("idle_digits", 32'(digits), 32'h0000);

    pulse_ss();
    periods(25);
    settle(5);
    chk("run25", 32'(digits), 32'h0025);
    chk("run25_model", 32'(to_bcd(m_count)), 32'h0025);
    pulse_ss();
    periods(5);
    settle(5);
    chk("pause_hold", 32'(digits), 32'h0025);
    chk("pause_running", 32'(running), 32'h0);
    pulse_ss();
    periods(5);
    settle(5);
    chk("resume", 32'(digits), 32'h0030);
    chk("resume_model", 32'(to_bcd(m_count)), 32'h0030);

    // edge latency
    @(negedge clk) slow = 1'b1;
    @(negedge clk) chk("lat_k", 32'(tick), 32'h0);
    @(negedge clk) chk("lat_k1", 32'(tick), 32'h0);
    @(negedge clk) begin
      chk("lat_k2_tick", 32'(tick), 32'h1);
      chk("lat_k2_digits", 32'(digits), 32'h0030);
    end
    @(negedge clk) begin
      chk("lat_k3_digits", 32'(digits), 32'h0031);
      chk("lat_k3_tick", 32'(tick), 32'h0);
      slow = 1'b0;
    end
    settle(4);

    // simultaneous events
    rise_with_cmd(1'b1, 1'b0);
    chk("run_ss_tick_digits", 32'(digits), 32'h0032);
    chk("run_ss_tick_running", 32'(running), 32'h0);
    rise_with_cmd(1'b1, 1'b0);
    chk("pause_ss_tick_digits", 32'(digits), 32'h0032);
    chk("pause_ss_tick_running", 32'(running), 32'h1);
    rise_with_cmd(1'b1, 1'b1);
    chk("clr_ss_tick_digits", 32'(digits), 32'h0000);
    chk("clr_ss_tick_running", 32'(running), 32'h0);

    // reset mid-operation, applied between edges
    pulse_ss();
    periods(42);
    settle(5);
    chk("pre_reset", 32'(digits), 32'h0042);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 begin
      chk("async_rst_digits", 32'(digits), 32'h0);
      chk("async_rst_running", 32'(running), 32'h0);
      chk("async_rst_tick", 32'(tick), 32'h0);
      chk("async_rst_wrap", 32'(wrap), 32'h0);
    end
    @(negedge clk) reset = 1'b0;
    periods(3);
    settle(5);
    chk("post_reset_digits", 32'(digits), 32'h0000);
    chk("post_reset_running", 32'(running), 32'h0);

    // BCD carry and wrap
    pulse_ss();
    periods(998);
    settle(5);
    chk("c998", 32'(digits), 32'h0998);
    t0 = wrap_seen;
    periods(1);
    settle(5);
    chk("c999", 32'(digits), 32'h0999);
    periods(1);
    settle(5);
    chk("c1000", 32'(digits), 32'h1000);
    chk("c1000_nowrap", 32'(wrap_seen - t0), 32'h0);
    periods(8999);
    settle(5);
    chk("c9999", 32'(digits), 32'h9999);
    periods(1);
    settle(5);
    chk("wrap_digits", 32'(digits), 32'h0000);
    chk("wrap_pulses", 32'(wrap_seen - t0), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);

    // random phases and commands against the model
    for (int i = 0; i < 200; i++) begin
      rand_phase(int'($urandom_range(3, 6)), 1'b1);
      rand_phase(int'($urandom_range(3, 6)), 1'b0);
    end
    @(negedge clk) begin ss = 1'b0; clr = 1'b0; end
    settle(5);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Counts rising edges of the slow square wave from the clock divider stage in a multi-digit BCD stopwatch register, with start/stop and clear control. It sits directly downstream of the divider: `slow_clock` is the divider's `clock_out`. It is treated as a data signal and re-synchronised into the fast `clock_in` domain; it is never used as a clock. Outputs drive the seven-segment/display stage.

## Interface
- `DIGITS`, default 4: number of BCD digits; count range 0 to 10^DIGITS−1.
- `clock_in`  in  1: single system clock. All flops are on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `slow_clock`  in  1: divided square wave from the clock divider. Asynchronous to use, synchronised internally.
- `start_stop`  in  1: single-cycle command pulse that toggles run/pause.
- `clear`  in  1: single-cycle command pulse that zeroes the count and returns to IDLE.
- `digits`  out  4*DIGITS: BCD count. Digit 0 (least significant) is in bits [3:0].
- `running`  out  1: high while the state is RUN.
- `tick`  out  1: one-cycle pulse per synchronised rising edge of `slow_clock`, regardless of state.
- `wrap`  out  1: one-cycle pulse when the count rolls from all-9s to 0.

## Operation
- Synchroniser and edge detector:
  - `s1 <= slow_clock`, `s2 <= s1`, `s3 <= s2`.
  - `tick <= s2 & ~s3` (registered).
  - One tick per `slow_clock` period, which is 2×divide_by `clock_in` cycles.
- State machine, 2-bit: IDLE, RUN, PAUSE.
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSE.
  - PAUSE + `start_stop` → RUN.
  - Any state + `clear` → IDLE.
  - `clear` has priority over `start_stop` in the same cycle.
- Counting:
  - On a cycle with `tick`=1 and current state RUN, the BCD count increments.
  - The decision uses the state before any same-cycle transition.
  - RUN + `start_stop` + `tick`: the tick is counted, then the state goes to PAUSE.
  - PAUSE or IDLE + `start_stop` + `tick`: the tick is not counted, then the state goes to RUN.
- BCD increment, ripple per digit:
  - Digit k increments if all lower digits are 9.
  - A digit at 9 that increments becomes 0.
  - Digit values 10–15 never occur; no binary arithmetic on the full vector.
- Wrap: count all-9s + counted tick → count 0, `wrap`=1 for one cycle, state stays RUN.
- Clear:
  - `digits` <= 0 and state <= IDLE, even if a tick is present in the same cycle.
  - `wrap` is not asserted.
- `running` is decoded from the state register, with no extra delay.

## Timing
- Reset values (asynchronous, immediate on `reset` rising):
  - `digits`=0, state IDLE, `running`=0, `tick`=0, `wrap`=0.
  - `s1`/`s2`/`s3`=0.
- Reset mid-count: the count is lost and the state goes to IDLE. A pending edge in the synchroniser is discarded.
- After reset is released with `slow_clock` already high, one `tick` pulse may appear. It is harmless because the state is IDLE.
- Edge latency: a `slow_clock` rise sampled at `clock_in` edge k gives `tick`=1 in the cycle after edge k+2. `digits` updates at edge k+3, so input-edge-to-count latency is 3–4 `clock_in` cycles.
- `start_stop`/`clear` sampled at edge n: the new state and `running` are visible after edge n; a clear zeroes `digits` at edge n.
- `wrap` is high in the same cycle that `digits` first reads 0.
- `slow_clock` high and low phases must each be ≥3 `clock_in` cycles. Shorter pulses may be missed and are not a required case.

## Test plan
- Reset and idle:
  - Assert `reset` mid-simulation. All outputs go to 0 asynchronously, without waiting for a clock.
  - Toggle `slow_clock` (period 6 clocks) for 10 periods in IDLE. `tick` pulses 10 times and `digits` stays 0x0000.
- Run, pause and resume:
  - Send `start_stop`, then 25 `slow_clock` periods: `digits`=0x0025.
  - Send `start_stop` (pause), then 5 periods: `digits` holds 0x0025.
  - Send `start_stop` again, then 5 periods: `digits`=0x0030.
- BCD carry and wrap:
  - Run from 0x0998 for 2 ticks: `digits` goes 0x0999 then 0x1000, with no `wrap`.
  - Run from 0x9999 for 1 tick: `digits`=0x0000, `wrap`=1 for exactly one cycle, `running` stays 1.
- Latency: drive the `slow_clock` rise just before edge k. `tick` is high in the cycle after edge k+2, and `digits` increments at edge k+3.
- Simultaneous events:
  - RUN + `start_stop` + `tick` in the same cycle: count +1, then PAUSE.
  - PAUSE + `start_stop` + `tick`: no increment, then RUN.
  - `clear` + `start_stop` + `tick`: `digits`=0 and state IDLE.
- Reset mid-operation: at count 0x0042 in RUN, pulse `reset` between clock edges. `digits`=0 and `running`=0 immediately. After release, `slow_clock` edges do not count until `start_stop` is sent.
